// File: rtl/ama_riscv_decode_stage.sv
// RV32I decode stage with a small decoded-entry buffer and a stall-tracking FSM.
// Optional RV32M decode is enabled by defining AMA_RISCV_RV32M_EN.

package ama_riscv_decode_pkg;
  typedef struct packed {
    logic [3:0] alu_op_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [2:0] ig_sel;
    logic       bc_uns;
    logic       dmem_en;
    logic       dmem_we;
    logic       load_sm_en;
    logic [1:0] wb_sel;
    logic       rd_we;
    logic       csr_en;
    logic       csr_we;
  } decoder_t;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_we;
    logic       branch_inst;
    logic       jump_inst;
  } fe_ctrl_t;

  localparam decoder_t DECODER_RST_VAL = '0;
  localparam fe_ctrl_t FE_CTRL_RST_VAL = '0;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [1:0] ALU_A_RS1 = 2'd0;
  localparam logic [1:0] ALU_A_PC  = 2'd1;
  localparam logic [1:0] ALU_B_RS2 = 2'd0;
  localparam logic [1:0] ALU_B_IMM = 2'd1;

  localparam logic [2:0] IG_DISABLED = 3'd0;
  localparam logic [2:0] IG_I_TYPE   = 3'd1;
  localparam logic [2:0] IG_S_TYPE   = 3'd2;
  localparam logic [2:0] IG_B_TYPE   = 3'd3;
  localparam logic [2:0] IG_J_TYPE   = 3'd4;
  localparam logic [2:0] IG_U_TYPE   = 3'd5;

  localparam logic [1:0] WB_DMEM = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_INC4 = 2'd2;
  localparam logic [1:0] WB_CSR  = 2'd3;

  localparam logic [1:0] PC_SEL_INC4 = 2'd0;
  localparam logic [1:0] PC_SEL_ALU  = 2'd1;

  localparam logic [1:0] ST_RST        = 2'd0;
  localparam logic [1:0] ST_STEADY     = 2'd1;
  localparam logic [1:0] ST_STALL_FLOW = 2'd2;
  localparam logic [1:0] ST_STALL_IMEM = 2'd3;
endpackage

module ama_riscv_decode_stage
  import ama_riscv_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_in,
  input  logic [31:0]      pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output decoder_t         decoded,
  output fe_ctrl_t         fe_ctrl,
  output logic [31:0]      pc_out,
  output logic             illegal,
  output logic             mul_inst,
  output logic [1:0]       stall_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef AMA_RISCV_RV32M_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    decoder_t    dec;
    fe_ctrl_t    fe;
    logic        ill;
    logic        mul;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  logic       rd_nz;
  logic       rs1_nz;
  logic       r_mul;
  decoder_t   dec_d;
  fe_ctrl_t   fe_d;
  logic       ill_d;
  logic       mul_d;
  logic       unused_rs2;

  assign opcode     = inst_in[6:0];
  assign fn3        = inst_in[14:12];
  assign fn7        = inst_in[31:25];
  assign rd_nz      = (inst_in[11:7] != 5'd0);
  assign rs1_nz     = (inst_in[19:15] != 5'd0);
  assign r_mul      = (fn7 == 7'b0000001);
  assign unused_rs2 = ^inst_in[24:20];

  always_comb begin
    dec_d = DECODER_RST_VAL;
    fe_d  = FE_CTRL_RST_VAL;
    ill_d = 1'b0;
    mul_d = 1'b0;
    fe_d.pc_we = 1'b1;
    case (opcode)
      OPC_R: begin
        if (r_mul && !M_EN) begin
          ill_d = 1'b1;
          fe_d  = FE_CTRL_RST_VAL;
        end else begin
          dec_d.alu_op_sel = r_mul ? {1'b0, fn3} : {fn7[5], fn3};
          dec_d.alu_a_sel  = ALU_A_RS1;
          dec_d.alu_b_sel  = ALU_B_RS2;
          dec_d.wb_sel     = WB_ALU;
          dec_d.rd_we      = rd_nz;
          mul_d            = r_mul && M_EN;
        end
      end
      OPC_I: begin
        // only shift-right immediates carry an opcode bit in fn7
        dec_d.alu_op_sel = (fn3 == 3'b101) ? {fn7[5], fn3} : {1'b0, fn3};
        dec_d.alu_b_sel  = ALU_B_IMM;
        dec_d.ig_sel     = IG_I_TYPE;
        dec_d.wb_sel     = WB_ALU;
        dec_d.rd_we      = rd_nz;
      end
      OPC_LOAD: begin
        dec_d.alu_b_sel  = ALU_B_IMM;
        dec_d.ig_sel     = IG_I_TYPE;
        dec_d.dmem_en    = 1'b1;
        dec_d.load_sm_en = 1'b1;
        dec_d.wb_sel     = WB_DMEM;
        dec_d.rd_we      = rd_nz;
      end
      OPC_STORE: begin
        dec_d.alu_b_sel = ALU_B_IMM;
        dec_d.ig_sel    = IG_S_TYPE;
        dec_d.dmem_en   = 1'b1;
        dec_d.dmem_we   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.alu_a_sel   = ALU_A_PC;
        dec_d.alu_b_sel   = ALU_B_IMM;
        dec_d.ig_sel      = IG_B_TYPE;
        dec_d.bc_uns      = fn3[1];
        fe_d.branch_inst  = 1'b1;
      end
      OPC_JALR: begin
        dec_d.alu_b_sel = ALU_B_IMM;
        dec_d.ig_sel    = IG_I_TYPE;
        dec_d.wb_sel    = WB_INC4;
        dec_d.rd_we     = rd_nz;
        fe_d.pc_sel     = PC_SEL_ALU;
        fe_d.jump_inst  = 1'b1;
      end
      OPC_JAL: begin
        dec_d.alu_a_sel = ALU_A_PC;
        dec_d.alu_b_sel = ALU_B_IMM;
        dec_d.ig_sel    = IG_J_TYPE;
        dec_d.wb_sel    = WB_INC4;
        dec_d.rd_we     = rd_nz;
        fe_d.pc_sel     = PC_SEL_ALU;
        fe_d.jump_inst  = 1'b1;
      end
      OPC_LUI: begin
        dec_d.alu_op_sel = ALU_PASS_B;
        dec_d.alu_b_sel  = ALU_B_IMM;
        dec_d.ig_sel     = IG_U_TYPE;
        dec_d.wb_sel     = WB_ALU;
        dec_d.rd_we      = rd_nz;
      end
      OPC_AUIPC: begin
        dec_d.alu_a_sel = ALU_A_PC;
        dec_d.alu_b_sel = ALU_B_IMM;
        dec_d.ig_sel    = IG_U_TYPE;
        dec_d.wb_sel    = WB_ALU;
        dec_d.rd_we     = rd_nz;
      end
      OPC_SYSTEM: begin
        // CSRRW-family always writes; set/clear forms write only with a nonzero source
        dec_d.csr_en = 1'b1;
        dec_d.csr_we = (fn3[1:0] == 2'b01) || rs1_nz;
        dec_d.wb_sel = WB_CSR;
        dec_d.rd_we  = rd_nz;
      end
      default: begin
        ill_d = 1'b1;
        fe_d  = FE_CTRL_RST_VAL;
      end
    endcase
  end

  entry_t        ent_mem [DEPTH];
  entry_t        head;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [1:0]    state;
  logic          push;
  logic          pop;

  assign in_ready  = (state != ST_RST) && (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign head      = ent_mem[rptr];

  assign decoded     = out_valid ? head.dec : DECODER_RST_VAL;
  assign fe_ctrl     = out_valid ? head.fe  : FE_CTRL_RST_VAL;
  assign pc_out      = out_valid ? head.pc  : 32'd0;
  assign illegal     = out_valid && head.ill;
  assign mul_inst    = out_valid && head.mul;
  assign stall_state = state;

  always_ff @(posedge clk) begin
    if (push) ent_mem[wptr] <= '{pc: pc_in, dec: dec_d, fe: fe_d, ill: ill_d, mul: mul_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RST;
    end else if (flush) begin
      state <= ST_STEADY;
    end else begin
      case (state)
        ST_RST:        state <= ST_STEADY;
        ST_STEADY: begin
          if (count == FULL && !out_ready)   state <= ST_STALL_FLOW;
          else if (count == '0 && !in_valid) state <= ST_STALL_IMEM;
        end
        ST_STALL_FLOW: if (pop)  state <= ST_STEADY;
        ST_STALL_IMEM: if (push) state <= ST_STEADY;
        default:       state <= ST_STEADY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == ST_STALL_FLOW || state == ST_STALL_IMEM) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ama_riscv_decode_stage.sv
// Directed bench for ama_riscv_decode_stage: decode vector table plus buffer/FSM sequences.
module tb_ama_riscv_decode_stage;
  import ama_riscv_decode_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      inst_in = '0;
  logic [31:0]      pc_in = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  decoder_t         decoded;
  fe_ctrl_t         fe_ctrl;
  logic [31:0]      pc_out;
  logic             illegal;
  logic             mul_inst;
  logic [1:0]       stall_state;
  logic [CNT_W-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  ama_riscv_decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .decoded(decoded), .fe_ctrl(fe_ctrl), .pc_out(pc_out),
    .illegal(illegal), .mul_inst(mul_inst), .stall_state(stall_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    decoder_t    dec;
    fe_ctrl_t    fe;
    logic        ill;
    logic        mul;
  } vec_t;

  vec_t vecs[$];

  function automatic decoder_t mk_dec(logic [3:0] alu, logic [1:0] a, logic [1:0] b,
                                      logic [2:0] ig, logic bcu, logic den, logic dwe,
                                      logic ld, logic [1:0] wb, logic rdwe, logic cen, logic cwe);
    decoder_t d;
    d = '{alu_op_sel: alu, alu_a_sel: a, alu_b_sel: b, ig_sel: ig, bc_uns: bcu,
          dmem_en: den, dmem_we: dwe, load_sm_en: ld, wb_sel: wb, rd_we: rdwe,
          csr_en: cen, csr_we: cwe};
    return d;
  endfunction

  function automatic fe_ctrl_t mk_fe(logic [1:0] sel, logic we, logic br, logic jmp);
    fe_ctrl_t f;
    f = '{pc_sel: sel, pc_we: we, branch_inst: br, jump_inst: jmp};
    return f;
  endfunction

  task automatic add_vec(string n, logic [31:0] i, decoder_t d, fe_ctrl_t f, logic il, logic m);
    vec_t v;
    v.name = n; v.inst = i; v.dec = d; v.fe = f; v.ill = il; v.mul = m;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " state"}, 64'(stall_state), 64'(ST_RST));
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, " illegal"}, 64'(illegal), 64'd0);
    chk({tag, " mul_inst"}, 64'(mul_inst), 64'd0);
    chk({tag, " decoded"}, 64'(decoded), 64'(DECODER_RST_VAL));
    chk({tag, " fe_ctrl"}, 64'(fe_ctrl), 64'(FE_CTRL_RST_VAL));
    chk({tag, " pc_out"}, 64'(pc_out), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fe_ctrl_t fe_seq;
    fe_seq = mk_fe(PC_SEL_INC4, 1, 0, 0);
    add_vec("addi", 32'h00500093, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_IMM, IG_I_TYPE, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("add",  32'h002081B3, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_RS2, IG_DISABLED, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("sub",  32'h402081B3, mk_dec(ALU_SUB, ALU_A_RS1, ALU_B_RS2, IG_DISABLED, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("lw",   32'h0040A283, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_IMM, IG_I_TYPE, 0,1,0,1, WB_DMEM, 1,0,0), fe_seq, 0, 0);
    add_vec("sw",   32'h0020A423, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_IMM, IG_S_TYPE, 0,1,1,0, WB_DMEM, 0,0,0), fe_seq, 0, 0);
    add_vec("beq",  32'h00208463, mk_dec(ALU_ADD, ALU_A_PC, ALU_B_IMM, IG_B_TYPE, 0,0,0,0, WB_DMEM, 0,0,0), mk_fe(PC_SEL_INC4, 1, 1, 0), 0, 0);
    add_vec("bltu", 32'h0020E463, mk_dec(ALU_ADD, ALU_A_PC, ALU_B_IMM, IG_B_TYPE, 1,0,0,0, WB_DMEM, 0,0,0), mk_fe(PC_SEL_INC4, 1, 1, 0), 0, 0);
    add_vec("jal",  32'h010000EF, mk_dec(ALU_ADD, ALU_A_PC, ALU_B_IMM, IG_J_TYPE, 0,0,0,0, WB_INC4, 1,0,0), mk_fe(PC_SEL_ALU, 1, 0, 1), 0, 0);
    add_vec("jalr_x0", 32'h00008067, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_IMM, IG_I_TYPE, 0,0,0,0, WB_INC4, 0,0,0), mk_fe(PC_SEL_ALU, 1, 0, 1), 0, 0);
    add_vec("lui",  32'h123452B7, mk_dec(ALU_PASS_B, ALU_A_RS1, ALU_B_IMM, IG_U_TYPE, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("auipc", 32'h00001317, mk_dec(ALU_ADD, ALU_A_PC, ALU_B_IMM, IG_U_TYPE, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("csrrw", 32'h300110F3, mk_dec(4'd0, 2'd0, 2'd0, IG_DISABLED, 0,0,0,0, WB_CSR, 1,1,1), fe_seq, 0, 0);
    add_vec("srai", 32'h4030D093, mk_dec(4'b1101, ALU_A_RS1, ALU_B_IMM, IG_I_TYPE, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 0);
    add_vec("nop",  32'h00000013, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_IMM, IG_I_TYPE, 0,0,0,0, WB_ALU, 0,0,0), fe_seq, 0, 0);
    add_vec("opc0", 32'h00000000, DECODER_RST_VAL, FE_CTRL_RST_VAL, 1, 0);
`ifdef AMA_RISCV_RV32M_EN
    add_vec("mul",  32'h022081B3, mk_dec(ALU_ADD, ALU_A_RS1, ALU_B_RS2, IG_DISABLED, 0,0,0,0, WB_ALU, 1,0,0), fe_seq, 0, 1);
`else
    add_vec("mul",  32'h022081B3, DECODER_RST_VAL, FE_CTRL_RST_VAL, 1, 0);
`endif

    do_reset();
    @(negedge clk);
    chk("post-rst state", 64'(stall_state), 64'(ST_STEADY));
    chk("post-rst in_ready", 64'(in_ready), 64'd1);

    // decode table: push each into an empty stage, check head, let it pop
    foreach (vecs[i]) begin
      in_valid = 1'b1; inst_in = vecs[i].inst; pc_in = 32'h100 + 32'(i) * 4; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, " out_valid"}, 64'(out_valid), 64'd1);
      chk({vecs[i].name, " decoded"}, 64'(decoded), 64'(vecs[i].dec));
      chk({vecs[i].name, " fe_ctrl"}, 64'(fe_ctrl), 64'(vecs[i].fe));
      chk({vecs[i].name, " illegal"}, 64'(illegal), 64'(vecs[i].ill));
      chk({vecs[i].name, " mul_inst"}, 64'(mul_inst), 64'(vecs[i].mul));
      chk({vecs[i].name, " pc_out"}, 64'(pc_out), 64'(32'h100 + 32'(i) * 4));
      @(negedge clk);
      chk({vecs[i].name, " popped"}, 64'(out_valid), 64'd0);
    end

    // back-pressure: fill, stall on flow, hold head, then drain with push+pop overlap
    do_reset();
    in_valid = 1'b1; inst_in = 32'h00500093; pc_in = 32'h200;
    @(negedge clk);
    chk("flow steady", 64'(stall_state), 64'(ST_STEADY));
    chk("flow no push in rst", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("flow first out_valid", 64'(out_valid), 64'd1);
    chk("flow first in_ready", 64'(in_ready), 64'd1);
    chk("flow first head", 64'(pc_out), 64'h200);
    pc_in = 32'h204; inst_in = 32'h002081B3;
    @(negedge clk);
    chk("flow full in_ready", 64'(in_ready), 64'd0);
    chk("flow full head", 64'(pc_out), 64'h200);
    pc_in = 32'h208; inst_in = 32'h402081B3;
    @(negedge clk);
    chk("flow state", 64'(stall_state), 64'(ST_STALL_FLOW));
    chk("flow cnt0", 64'(stall_cnt), 64'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("flow cnt", 64'(stall_cnt), 64'(k));
      chk("flow hold pc", 64'(pc_out), 64'h200);
      chk("flow hold dec", 64'(decoded), 64'(vecs[0].dec));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("flow pop head", 64'(pc_out), 64'h204);
    chk("flow back steady", 64'(stall_state), 64'(ST_STEADY));
    chk("flow cnt frozen", 64'(stall_cnt), 64'd3);
    chk("flow in_ready back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pushpop head", 64'(pc_out), 64'h208);
    chk("pushpop out_valid", 64'(out_valid), 64'd1);
    chk("pushpop dec", 64'(decoded), 64'(vecs[2].dec));
    @(negedge clk);
    chk("drained", 64'(out_valid), 64'd0);

    // flush of a full buffer with a same-cycle input
    out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'h00500093; pc_in = 32'h300;
    @(negedge clk);
    pc_in = 32'h304;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-flush state", 64'(stall_state), 64'(ST_STALL_FLOW));
    flush = 1'b1; in_valid = 1'b1; pc_in = 32'h3FC;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush state", 64'(stall_state), 64'(ST_STEADY));
    @(negedge clk);
    chk("flush dropped", 64'(out_valid), 64'd0);

    // fetch starvation, counter saturation, then reset with an entry buffered
    do_reset();
    repeat (10) @(negedge clk);
    chk("imem state", 64'(stall_state), 64'(ST_STALL_IMEM));
    chk("imem cnt8", 64'(stall_cnt), 64'd8);
    repeat (10) @(negedge clk);
    chk("imem saturated", 64'(stall_cnt), 64'd15);
    in_valid = 1'b1; inst_in = 32'h022081B3; pc_in = 32'h400;
    @(negedge clk);
    in_valid = 1'b0;
    chk("imem push valid", 64'(out_valid), 64'd1);
    chk("imem push steady", 64'(stall_state), 64'(ST_STEADY));
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst discarded", 64'(out_valid), 64'd0);
    chk("midrst steady", 64'(stall_state), 64'(ST_STEADY));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ama_riscv_decode_stage.md
AMA_RISCV_DECODE_STAGE -- requirements
Module: ama_riscv_decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of decoded-entry buffer slots (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port inst_in  input  32  raw instruction word.
REQ-008 SHALL have port pc_in  input  32  PC of inst_in.
REQ-009 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  execute consumes the head entry.
REQ-012 SHALL have port decoded  output  decoder_t  decoded controls of the head entry.
REQ-013 SHALL have port fe_ctrl  output  fe_ctrl_t  front-end controls of the head entry.
REQ-014 SHALL have port pc_out  output  32  PC of the head entry.
REQ-015 SHALL have port illegal  output  1  head entry has an unsupported encoding.
REQ-016 SHALL have port mul_inst  output  1  head entry is an RV32M operation.
REQ-017 SHALL have port stall_state  output  2  current FSM state (RST=0, STEADY=1, STALL_FLOW=2, STALL_IMEM=3).
REQ-018 SHALL have port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-019 SHALL decode inst_in combinationally and write {pc, decoded, fe_ctrl, illegal, mul_inst} into the buffer on push = in_valid && in_ready && !flush.
REQ-020 SHALL decode opcode classes R, I, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC and SYSTEM (CSR) with the existing single-cycle decoder field mapping; rd_we=0 when rd=x0.
REQ-021 SHALL, for any other opcode, emit DECODER_RST_VAL/FE_CTRL_RST_VAL fields with illegal=1 and still pass the entry downstream.
REQ-022 SHALL present a pushed entry at the outputs one cycle after the push edge (no bypass, latency 1 when empty).
REQ-023 SHALL drive in_ready = (count != DEPTH) from registered count only; a push is never accepted when full, even with a simultaneous pop.
REQ-024 SHALL pop the head on out_valid && out_ready; out_valid = (count != 0).
REQ-025 SHALL support simultaneous push and pop when not full, leaving count unchanged.
REQ-026 SHALL wrap read/write pointers modulo DEPTH (log2(DEPTH) bits).
REQ-027 SHALL, on flush, clear count and pointers at the edge, drop any same-cycle input, and hold out_valid=0 the following cycle.
REQ-028 SHALL hold decoded/fe_ctrl/pc_out stable while out_valid && !out_ready.
REQ-029 SHALL implement the FSM: RST->STEADY on first clock after reset release; STEADY->STALL_FLOW when count==DEPTH && !out_ready; STEADY->STALL_IMEM when count==0 && !in_valid; STALL_FLOW->STEADY on pop; STALL_IMEM->STEADY on push; any state->STEADY on flush.
REQ-030 SHALL increment stall_cnt every cycle the state is STALL_FLOW or STALL_IMEM, saturating at all-ones.

Reset
REQ-031 SHALL, while rst=1, force count=0, pointers=0, stall_state=RST, stall_cnt=0, out_valid=0, in_ready=0, illegal=0, mul_inst=0, decoded=DECODER_RST_VAL, fe_ctrl=FE_CTRL_RST_VAL, pc_out=0.
REQ-032 SHALL discard all buffered entries on reset asserted mid-operation, with no partial pop or push.

Configuration
REQ-033 SHALL honour macro AMA_RISCV_RV32M_EN: when defined, R-type with fn7=7'b0000001 sets mul_inst=1, illegal=0, alu_op_sel={1'b0,fn3}, rd_we per REQ-020.
REQ-034 SHALL, without AMA_RISCV_RV32M_EN, tie mul_inst=0 and flag fn7=7'b0000001 R-type encodings illegal=1.

Verification
REQ-035 SHALL cover: ADDI x1,x0,5 (0x00500093) pushed into empty stage -> out_valid=1 next cycle, alu_b_sel=IMM, ig_sel=I_TYPE, rd_we=1.
REQ-036 SHALL cover: DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after 2nd, third held, stall_state=STALL_FLOW, stall_cnt increments per cycle.
REQ-037 SHALL cover: full buffer, flush=1 with in_valid=1 -> count=0, out_valid=0 next cycle, input dropped, state=STEADY.
REQ-038 SHALL cover: opcode 7'b0000000 -> illegal=1, decoded=DECODER_RST_VAL, entry still popped normally.
REQ-039 SHALL cover: MUL x3,x1,x2 (0x022081B3) -> mul_inst=1 illegal=0 with AMA_RISCV_RV32M_EN, illegal=1 mul_inst=0 without.
REQ-040 SHALL cover: CNT_W=4 with in_valid=0 for 20 cycles -> stall_state=STALL_IMEM, stall_cnt saturates at 15; rst mid-run returns all outputs to REQ-031 values.
